// File: rtl/run_interruption_golomb_decoder_pkg.sv
// Shared widths, code-length limits and FSM state type for the
// run-interruption Golomb decoder.
package run_interruption_golomb_decoder_pkg;
  localparam int unsigned A_length    = 13;
  localparam int unsigned N_length    = 7;
  localparam int unsigned temp_length = 14;
  localparam int unsigned bpp         = 8;
  localparam int unsigned qbpp        = 8;
  localparam int unsigned LIMIT       = 32;
  localparam int unsigned K_MAX       = 15;
  localparam int unsigned EM_length   = 16;

  typedef enum logic [2:0] {
    IDLE,
    CALC_K,
    UNARY,
    BINARY,
    ESCAPE,
    MAP,
    DONE
  } ri_state_t;
endpackage

// File: rtl/run_interruption_golomb_decoder_if.sv
// Context, serial-bit handshake and result bus of the run-interruption
// Golomb decoder.
interface run_interruption_golomb_decoder_if;
  import run_interruption_golomb_decoder_pkg::*;

  logic                   start;
  logic [A_length-1:0]    A_Select;
  logic [N_length-1:0]    N_Select;
  logic [N_length-1:0]    Nn_Select;
  logic                   RIType;
  logic [4:0]             J_value;
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic                   busy;
  logic                   done;
  logic [4:0]             k_out;
  logic [EM_length-1:0]   EMErrval;
  logic signed [bpp:0]    Errval;

  modport master (
    output start, A_Select, N_Select, Nn_Select, RIType, J_value, bit_in, bit_valid,
    input  bit_ready, busy, done, k_out, EMErrval, Errval
  );

  modport slave (
    input  start, A_Select, N_Select, Nn_Select, RIType, J_value, bit_in, bit_valid,
    output bit_ready, busy, done, k_out, EMErrval, Errval
  );
endinterface

// File: rtl/run_interruption_golomb_decoder_ri_inverse_map.sv
// Inverse run-interruption error mapping: EMErrval (+RIType) back to a
// signed Errval. Only the low bpp+2 bits of the mapped value matter here.
module ri_inverse_map
  import run_interruption_golomb_decoder_pkg::*;
(
  input  logic [bpp+1:0]      value,
  input  logic                RIType,
  input  logic [4:0]          k,
  input  logic [N_length-1:0] N,
  input  logic [N_length-1:0] Nn,
  output logic signed [bpp:0] Errval
);
  logic [bpp+1:0] t;
  logic [bpp:0]   mag;
  logic           map;
  logic           cond;

  // (t + map) >> 1 rewritten as (t >> 1) + map to stay in bpp+1 bits
  always_comb begin
    t      = value + {{(bpp+1){1'b0}}, RIType};
    map    = t[0];
    mag    = t[bpp+1:1] + {{bpp{1'b0}}, map};
    cond   = (k == 5'd0) && ({Nn, 1'b0} < {1'b0, N});
    Errval = (map ^ cond) ? ('0 - mag) : mag;
  end
endmodule

// File: rtl/run_interruption_golomb_decoder.sv
// Run-interruption Golomb decoder: derives k from the latched context,
// decodes the limited-length Golomb code bit-serially and inverse-maps
// the result to a signed Errval.
module run_interruption_golomb_decoder
  import run_interruption_golomb_decoder_pkg::*;
(
  input logic clk,
  input logic reset,
  run_interruption_golomb_decoder_if.slave bus
);
  localparam int unsigned SH_length = temp_length + K_MAX;

  ri_state_t              state;
  logic [temp_length-1:0] temp_in;
  logic [temp_length-1:0] temp_q;
  logic [N_length-1:0]    n_q;
  logic [N_length-1:0]    nn_q;
  logic                   ri_q;
  logic signed [7:0]      q_thresh;
  logic [4:0]             k_q;
  logic [4:0]             q_q;
  logic [4:0]             count_q;
  logic [EM_length-1:0]   value_q;
  logic [SH_length-1:0]   n_shift;
  logic signed [bpp:0]    errval_c;

  assign temp_in = bus.RIType ? temp_length'(bus.A_Select) + temp_length'(bus.N_Select >> 1)
                              : temp_length'(bus.A_Select);

  assign n_shift = SH_length'(n_q) << k_q;

  ri_inverse_map u_map (
    .value  (value_q[bpp+1:0]),
    .RIType (ri_q),
    .k      (k_q),
    .N      (n_q),
    .Nn     (nn_q),
    .Errval (errval_c)
  );

  // Decode FSM: k search, unary prefix, binary/escape suffix, map, done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.bit_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.k_out     <= '0;
      bus.EMErrval  <= '0;
      bus.Errval    <= '0;
      temp_q        <= '0;
      n_q           <= '0;
      nn_q          <= '0;
      ri_q          <= 1'b0;
      q_thresh      <= '0;
      k_q           <= '0;
      q_q           <= '0;
      count_q       <= '0;
      value_q       <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            temp_q   <= temp_in;
            n_q      <= bus.N_Select;
            nn_q     <= bus.Nn_Select;
            ri_q     <= bus.RIType;
            // glimit - qbpp - 1 with glimit = LIMIT - J - 1
            q_thresh <= 8'(LIMIT - qbpp - 2) - {3'b000, bus.J_value};
            k_q      <= '0;
            q_q      <= '0;
            bus.busy <= 1'b1;
            state    <= CALC_K;
          end
        end
        CALC_K: begin
          if ((n_shift >= SH_length'(temp_q)) || (k_q == 5'(K_MAX))) begin
            bus.bit_ready <= 1'b1;
            state         <= UNARY;
          end else begin
            k_q <= k_q + 5'd1;
          end
        end
        UNARY: begin
          if (bus.bit_valid) begin
            if (!bus.bit_in) begin
              if (q_q != '1) q_q <= q_q + 5'd1;
            end else if ($signed({3'b000, q_q}) < q_thresh) begin
              value_q <= EM_length'(q_q);
              if (k_q == 5'd0) begin
                bus.bit_ready <= 1'b0;
                state         <= MAP;
              end else begin
                count_q <= k_q;
                state   <= BINARY;
              end
            end else begin
              value_q <= '0;
              count_q <= 5'(qbpp);
              state   <= ESCAPE;
            end
          end
        end
        BINARY: begin
          if (bus.bit_valid) begin
            value_q <= {value_q[EM_length-2:0], bus.bit_in};
            count_q <= count_q - 5'd1;
            if (count_q == 5'd1) begin
              bus.bit_ready <= 1'b0;
              state         <= MAP;
            end
          end
        end
        ESCAPE: begin
          if (bus.bit_valid) begin
            count_q <= count_q - 5'd1;
            if (count_q == 5'd1) begin
              value_q       <= {value_q[EM_length-2:0], bus.bit_in} + EM_length'(1);
              bus.bit_ready <= 1'b0;
              state         <= MAP;
            end else begin
              value_q <= {value_q[EM_length-2:0], bus.bit_in};
            end
          end
        end
        MAP: begin
          bus.EMErrval <= value_q;
          bus.Errval   <= errval_c;
          bus.k_out    <= k_q;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_run_interruption_golomb_decoder.sv
// Directed self-checking bench for run_interruption_golomb_decoder.
module tb_run_interruption_golomb_decoder;
  import run_interruption_golomb_decoder_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  run_interruption_golomb_decoder_if bus();

  run_interruption_golomb_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one decode: context + start, then bits MSB-first (bits[nbits-1] first).
  // Optional stall of stall_len cycles when bit index stall_at is next, and an
  // extra start pulse with junk context at cycle busy_start_at.
  task automatic run_decode(input logic [A_length-1:0] a, input logic [N_length-1:0] n,
                            input logic [N_length-1:0] nn, input logic ri, input logic [4:0] j,
                            input logic [63:0] bits, input int nbits,
                            input int stall_at, input int stall_len, input int busy_start_at,
                            output int cycles, output logic finished, output logic stall_ok);
    int   idx;
    int   stall_cnt;
    int   cyc;
    logic acc;
    logic stalled;
    idx = 0; stall_cnt = 0; cyc = 0; finished = 1'b0; stall_ok = 1'b1;
    @(negedge clk);
    while (bus.done) @(negedge clk);
    bus.A_Select = a; bus.N_Select = n; bus.Nn_Select = nn; bus.RIType = ri; bus.J_value = j;
    bus.bit_valid = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 300) begin
      stalled = 1'b0;
      if (idx == stall_at && stall_cnt < stall_len) begin
        bus.bit_valid = 1'b0; stall_cnt++; stalled = 1'b1;
      end else if (idx < nbits) begin
        bus.bit_valid = 1'b1; bus.bit_in = bits[nbits-1-idx];
      end else begin
        bus.bit_valid = 1'b0;
      end
      bus.start = (cyc == busy_start_at);
      if (bus.start) begin
        bus.A_Select = '1; bus.N_Select = 7'd1; bus.Nn_Select = '0; bus.RIType = 1'b1; bus.J_value = 5'd20;
      end
      acc = bus.bit_valid && bus.bit_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (stalled && !(bus.bit_ready === 1'b1 && bus.busy === 1'b1 && bus.done === 1'b0)) stall_ok = 1'b0;
      if (bus.done === 1'b1) finished = 1'b1;
    end
    bus.start = 1'b0;
    bus.bit_valid = 1'b0;
    cycles = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.bit_ready !== 1'b0) begin n_fail++; $display("FAIL reset_bit_ready: got %b expected 0", bus.bit_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.k_out !== 5'd0) begin n_fail++; $display("FAIL reset_k_out: got %0d expected 0", bus.k_out); end
    n_checks++; if (bus.EMErrval !== 16'd0) begin n_fail++; $display("FAIL reset_EMErrval: got %0d expected 0", bus.EMErrval); end
    n_checks++; if (bus.Errval !== 9'sd0) begin n_fail++; $display("FAIL reset_Errval: got %0d expected 0", bus.Errval); end
    reset = 1'b0;
  endtask

  task automatic test_regular_k2();
    int cyc; logic fin; logic sok;
    run_decode(13'd10, 7'd4, 7'd1, 1'b0, 5'd0, 64'b0110, 4, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1) begin n_fail++; $display("FAIL k2_timeout: got done=%b expected 1", fin); end
    n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL k2_latency: got %0d expected 9", cyc); end
    n_checks++; if (bus.k_out !== 5'd2) begin n_fail++; $display("FAIL k2_k: got %0d expected 2", bus.k_out); end
    n_checks++; if (bus.EMErrval !== 16'd6) begin n_fail++; $display("FAIL k2_EMErrval: got %0d expected 6", bus.EMErrval); end
    n_checks++; if (bus.Errval !== 9'sd3) begin n_fail++; $display("FAIL k2_Errval: got %0d expected 3", bus.Errval); end
    n_checks++; if (bus.busy !== 1'b0 || bus.bit_ready !== 1'b0) begin n_fail++; $display("FAIL k2_idle_flags: got busy=%b ready=%b expected 0 0", bus.busy, bus.bit_ready); end
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL k2_done_pulse: got %b expected 0", bus.done); end
    n_checks++; if (bus.Errval !== 9'sd3) begin n_fail++; $display("FAIL k2_Errval_held: got %0d expected 3", bus.Errval); end
  endtask

  task automatic test_k0_cond();
    int cyc; logic fin; logic sok;
    run_decode(13'd3, 7'd4, 7'd1, 1'b0, 5'd0, 64'b001, 3, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 6) begin n_fail++; $display("FAIL k0_latency: got %0d (done=%b) expected 6", cyc, fin); end
    n_checks++; if (bus.k_out !== 5'd0) begin n_fail++; $display("FAIL k0_k: got %0d expected 0", bus.k_out); end
    n_checks++; if (bus.EMErrval !== 16'd2) begin n_fail++; $display("FAIL k0_EMErrval: got %0d expected 2", bus.EMErrval); end
    n_checks++; if (bus.Errval !== -9'sd1) begin n_fail++; $display("FAIL k0_Errval: got %0d expected -1", bus.Errval); end
  endtask

  task automatic test_escape();
    int cyc; logic fin; logic sok;
    // 22 zeros, 1, 00000100
    run_decode(13'd1, 7'd1, 7'd1, 1'b1, 5'd0, 64'h104, 31, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 34) begin n_fail++; $display("FAIL esc_latency: got %0d (done=%b) expected 34", cyc, fin); end
    n_checks++; if (bus.k_out !== 5'd0) begin n_fail++; $display("FAIL esc_k: got %0d expected 0", bus.k_out); end
    n_checks++; if (bus.EMErrval !== 16'd5) begin n_fail++; $display("FAIL esc_EMErrval: got %0d expected 5", bus.EMErrval); end
    n_checks++; if (bus.Errval !== 9'sd3) begin n_fail++; $display("FAIL esc_Errval: got %0d expected 3", bus.Errval); end
  endtask

  task automatic test_odd_t();
    int cyc; logic fin; logic sok;
    run_decode(13'd5, 7'd4, 7'd3, 1'b0, 5'd0, 64'b011, 3, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 7) begin n_fail++; $display("FAIL odd_latency: got %0d (done=%b) expected 7", cyc, fin); end
    n_checks++; if (bus.k_out !== 5'd1) begin n_fail++; $display("FAIL odd_k: got %0d expected 1", bus.k_out); end
    n_checks++; if (bus.EMErrval !== 16'd3) begin n_fail++; $display("FAIL odd_EMErrval: got %0d expected 3", bus.EMErrval); end
    n_checks++; if (bus.Errval !== -9'sd2) begin n_fail++; $display("FAIL odd_Errval: got %0d expected -2", bus.Errval); end
  endtask

  // J=10 gives an escape threshold of 12: q=11 stays regular, q=12 escapes
  task automatic test_glimit_boundary();
    int cyc; logic fin; logic sok;
    run_decode(13'd3, 7'd4, 7'd3, 1'b0, 5'd10, 64'h001, 12, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 15) begin n_fail++; $display("FAIL q11_latency: got %0d (done=%b) expected 15", cyc, fin); end
    n_checks++; if (bus.EMErrval !== 16'd11) begin n_fail++; $display("FAIL q11_EMErrval: got %0d expected 11", bus.EMErrval); end
    n_checks++; if (bus.Errval !== -9'sd6) begin n_fail++; $display("FAIL q11_Errval: got %0d expected -6", bus.Errval); end
    run_decode(13'd3, 7'd4, 7'd3, 1'b0, 5'd10, 64'h100, 21, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 24) begin n_fail++; $display("FAIL q12_latency: got %0d (done=%b) expected 24", cyc, fin); end
    n_checks++; if (bus.EMErrval !== 16'd1) begin n_fail++; $display("FAIL q12_EMErrval: got %0d expected 1", bus.EMErrval); end
    n_checks++; if (bus.Errval !== -9'sd1) begin n_fail++; $display("FAIL q12_Errval: got %0d expected -1", bus.Errval); end
  endtask

  task automatic test_stall();
    int cyc; logic fin; logic sok;
    run_decode(13'd10, 7'd4, 7'd1, 1'b0, 5'd0, 64'b0110, 4, 3, 5, -1, cyc, fin, sok);
    n_checks++; if (sok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got flags_ok=%b expected 1", sok); end
    n_checks++; if (fin !== 1'b1 || cyc != 14) begin n_fail++; $display("FAIL stall_latency: got %0d (done=%b) expected 14", cyc, fin); end
    n_checks++; if (bus.EMErrval !== 16'd6) begin n_fail++; $display("FAIL stall_EMErrval: got %0d expected 6", bus.EMErrval); end
    n_checks++; if (bus.Errval !== 9'sd3) begin n_fail++; $display("FAIL stall_Errval: got %0d expected 3", bus.Errval); end
  endtask

  task automatic test_reset_mid();
    int seen_done; int cyc; logic fin; logic sok;
    seen_done = 0;
    @(negedge clk);
    while (bus.done) @(negedge clk);
    bus.A_Select = 13'd1; bus.N_Select = 7'd1; bus.Nn_Select = 7'd1; bus.RIType = 1'b1; bus.J_value = 5'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.bit_valid = 1'b1; bus.bit_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b1 || bus.bit_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got busy=%b ready=%b expected 1 1", bus.busy, bus.bit_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.bit_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.bit_ready !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rmid_abort: got busy=%b ready=%b done=%b expected 0 0 0", bus.busy, bus.bit_ready, bus.done); end
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses expected 0", seen_done); end
    run_decode(13'd10, 7'd4, 7'd1, 1'b0, 5'd0, 64'b0110, 4, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 9) begin n_fail++; $display("FAIL rmid_next_latency: got %0d (done=%b) expected 9", cyc, fin); end
    n_checks++; if (bus.EMErrval !== 16'd6 || bus.Errval !== 9'sd3) begin n_fail++; $display("FAIL rmid_next_result: got %0d/%0d expected 6/3", bus.EMErrval, bus.Errval); end
  endtask

  task automatic test_start_while_busy();
    int cyc; logic fin; logic sok;
    run_decode(13'd10, 7'd4, 7'd1, 1'b0, 5'd0, 64'b0110, 4, -1, 0, 4, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 9) begin n_fail++; $display("FAIL busy_start_latency: got %0d (done=%b) expected 9", cyc, fin); end
    n_checks++; if (bus.k_out !== 5'd2) begin n_fail++; $display("FAIL busy_start_k: got %0d expected 2", bus.k_out); end
    n_checks++; if (bus.EMErrval !== 16'd6 || bus.Errval !== 9'sd3) begin n_fail++; $display("FAIL busy_start_result: got %0d/%0d expected 6/3", bus.EMErrval, bus.Errval); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic fin; logic sok;
    run_decode(13'd5, 7'd4, 7'd3, 1'b0, 5'd0, 64'b011, 3, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || bus.Errval !== -9'sd2) begin n_fail++; $display("FAIL b2b_first: got %0d (done=%b) expected -2", bus.Errval, fin); end
    run_decode(13'd3, 7'd4, 7'd1, 1'b0, 5'd0, 64'b001, 3, -1, 0, -1, cyc, fin, sok);
    n_checks++; if (fin !== 1'b1 || cyc != 6) begin n_fail++; $display("FAIL b2b_second_latency: got %0d (done=%b) expected 6", cyc, fin); end
    n_checks++; if (bus.k_out !== 5'd0 || bus.EMErrval !== 16'd2 || bus.Errval !== -9'sd1) begin n_fail++; $display("FAIL b2b_second_result: got k=%0d em=%0d err=%0d expected 0 2 -1", bus.k_out, bus.EMErrval, bus.Errval); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.start = 1'b0; bus.A_Select = '0; bus.N_Select = '0; bus.Nn_Select = '0;
    bus.RIType = 1'b0; bus.J_value = '0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
    test_reset();
    test_regular_k2();
    test_k0_cond();
    test_escape();
    test_odd_t();
    test_glimit_boundary();
    test_stall();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
